// File: rtl/iter_alu.sv
// ---------------------------------------------------------------------------
// iter_alu
// Registered ALU for the multi-cycle core. Single-cycle ops (add/sub, logic,
// compares, shifts) finish in one cycle; MUL/MULHU use a shift-add multiplier
// and DIVU/REMU a restoring divider, each retiring one bit per cycle.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-low reset
//   in_valid/in_ready   operand handshake; in_ready is high only when idle
//   A, B, ALUControl    operands and 4-bit op code, latched at accept
//   out_valid/out_ready result handshake; Result/flags held until taken
//   Result              registered result
//   Z, N, V, C          zero, negative, signed overflow, carry (V/C add/sub)
// ---------------------------------------------------------------------------
module iter_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             C
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_SLTU  = 4'b0110;
  localparam logic [3:0] OP_SLL   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   result_q;
  logic               zFlag_q;
  logic               nFlag_q;
  logic               vFlag_q;
  logic               cFlag_q;
  logic [SW-1:0]      count_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               opHigh_q;

  logic               isSub;
  logic [WIDTH-1:0]   bAdd;
  logic [WIDTH:0]     addFull;
  logic               addOvf;
  logic [SW-1:0]      shamt;
  logic signed [WIDTH-1:0] sraRes;
  logic [WIDTH-1:0]   singleRes;
  logic               singleV;
  logic               singleC;

  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulAcc_d;
  logic [WIDTH:0]     divShift;
  logic [WIDTH:0]     divDiff;
  logic [2*WIDTH-1:0] divAcc_d;
  logic [WIDTH-1:0]   mulRes;
  logic [WIDTH-1:0]   divRes;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Result    = result_q;
  assign Z         = zFlag_q;
  assign N         = nFlag_q;
  assign V         = vFlag_q;
  assign C         = cFlag_q;

  // Single-cycle datapath, evaluated straight from the live inputs so the
  // result can be registered on the accept edge. SUB reuses the adder as
  // A + ~B + 1, which makes C=1 mean "no borrow".
  always_comb begin
    isSub     = (ALUControl == OP_SUB);
    bAdd      = isSub ? ~B : B;
    addFull   = {1'b0, A} + {1'b0, bAdd} + {{WIDTH{1'b0}}, isSub};
    addOvf    = (A[WIDTH-1] ^ addFull[WIDTH-1]) & ~(A[WIDTH-1] ^ B[WIDTH-1] ^ isSub);
    shamt     = B[SW-1:0];
    sraRes    = $signed(A) >>> shamt;
    singleRes = '0;
    singleV   = 1'b0;
    singleC   = 1'b0;
    case (ALUControl)
      OP_ADD, OP_SUB: begin
        singleRes = addFull[WIDTH-1:0];
        singleV   = addOvf;
        singleC   = addFull[WIDTH];
      end
      OP_AND:  singleRes = A & B;
      OP_OR:   singleRes = A | B;
      OP_XOR:  singleRes = A ^ B;
      OP_SLT:  singleRes = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: singleRes = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  singleRes = A << shamt;
      OP_SRL:  singleRes = A >> shamt;
      OP_SRA:  singleRes = sraRes;
      // Only reached here when B==0; non-zero divisors go to the DIV state.
      OP_DIVU: singleRes = '1;
      OP_REMU: singleRes = A;
      default: singleRes = '0;
    endcase
  end

  // One iteration step for each iterative unit. The multiplier keeps
  // {high partial product, remaining multiplier bits} in acc_q and shifts
  // right; the divider keeps {remainder, dividend/quotient bits} and shifts
  // left, restoring the remainder when the trial subtraction goes negative.
  always_comb begin
    mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mulAcc_d = {mulSum, acc_q[WIDTH-1:1]};
    divShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    divDiff  = divShift - {1'b0, opnd_q};
    if (divDiff[WIDTH]) begin
      divAcc_d = {divShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      divAcc_d = {divDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
    mulRes = opHigh_q ? mulAcc_d[2*WIDTH-1:WIDTH] : mulAcc_d[WIDTH-1:0];
    divRes = opHigh_q ? divAcc_d[2*WIDTH-1:WIDTH] : divAcc_d[WIDTH-1:0];
  end

  // Control FSM with registered result and flags. The last iteration step
  // and the result capture happen on the same edge, giving WIDTH+1 cycles
  // from accept to out_valid for the iterative ops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      zFlag_q  <= 1'b0;
      nFlag_q  <= 1'b0;
      vFlag_q  <= 1'b0;
      cFlag_q  <= 1'b0;
      count_q  <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      opHigh_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (ALUControl == OP_MUL || ALUControl == OP_MULHU) begin
              state_q  <= MUL;
              acc_q    <= {{WIDTH{1'b0}}, B};
              opnd_q   <= A;
              opHigh_q <= (ALUControl == OP_MULHU);
              count_q  <= SW'(WIDTH - 1);
            end else if ((ALUControl == OP_DIVU || ALUControl == OP_REMU) && (B != '0)) begin
              state_q  <= DIV;
              acc_q    <= {{WIDTH{1'b0}}, A};
              opnd_q   <= B;
              opHigh_q <= (ALUControl == OP_REMU);
              count_q  <= SW'(WIDTH - 1);
            end else begin
              state_q  <= DONE;
              result_q <= singleRes;
              zFlag_q  <= (singleRes == '0);
              nFlag_q  <= singleRes[WIDTH-1];
              vFlag_q  <= singleV;
              cFlag_q  <= singleC;
            end
          end
        end
        MUL: begin
          acc_q   <= mulAcc_d;
          count_q <= count_q - 1'b1;
          if (count_q == '0) begin
            state_q  <= DONE;
            result_q <= mulRes;
            zFlag_q  <= (mulRes == '0);
            nFlag_q  <= mulRes[WIDTH-1];
            vFlag_q  <= 1'b0;
            cFlag_q  <= 1'b0;
          end
        end
        DIV: begin
          acc_q   <= divAcc_d;
          count_q <= count_q - 1'b1;
          if (count_q == '0) begin
            state_q  <= DONE;
            result_q <= divRes;
            zFlag_q  <= (divRes == '0);
            nFlag_q  <= divRes[WIDTH-1];
            vFlag_q  <= 1'b0;
            cFlag_q  <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Parametrised, registered successor to the core's combinational ALU: WIDTH-bit datapath with a 4-bit op code.
- Keeps the existing op encodings for ADD/SUB/AND/OR/SLT and adds XOR, SLTU, shifts, and iterative RV32M-subset multiply/divide (MUL, MULHU, DIVU, REMU).
- Sits between decode and writeback of the multi-cycle core.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
WIDTH, 32, datapath width; power of two, >= 8. Shift amount = low $clog2(WIDTH) bits of B.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-low reset
in_valid  input  1  operands/op valid
in_ready  output  1  block can accept (high only in IDLE)
A  input  WIDTH  operand A
B  input  WIDTH  operand B
ALUControl  input  4  op: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 MUL, 1011 MULHU, 1100 DIVU, 1101 REMU, 1110/1111 reserved
out_valid  output  1  Result/flags valid
out_ready  input  1  consumer takes result
Result  output  WIDTH  registered result
Z  output  1  Result == 0
N  output  1  Result[WIDTH-1]
V  output  1  signed overflow (ADD/SUB only, else 0)
C  output  1  carry out (ADD/SUB only, else 0; SUB C=1 means no borrow)

Behaviour:
- Reset (rst==0 at clk edge):
  - State goes to IDLE; Result=0, Z=0, N=0, V=0, C=0, out_valid=0, counter=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation abandons the op; no result is produced.
- Handshake:
  - Accept occurs when in_valid && in_ready. A, B and ALUControl are latched at accept; inputs are don't-care afterwards.
  - Result leaves when out_valid && out_ready.
  - in_ready = (state==IDLE). No new accept in the cycle the result leaves; throughput is at most one op per 2 cycles.
- States:
  - IDLE: on accept with a single-cycle op (0000-1001, reserved, DIVU/REMU with B==0) -> DONE, Result/flags registered at that edge.
  - IDLE: on accept with MUL/MULHU -> MUL. With DIVU/REMU and B!=0 -> DIV. Counter loaded WIDTH-1.
  - MUL: shift-add, one multiplier bit per cycle, 2*WIDTH accumulator, WIDTH cycles. At counter==0 -> DONE with MUL = product[WIDTH-1:0], MULHU = product[2W-1:W] (both unsigned).
  - DIV: restoring unsigned division, one quotient bit per cycle, WIDTH cycles. At counter==0 -> DONE with DIVU = quotient, REMU = remainder.
  - DONE: out_valid=1. Result and flags held stable while out_ready=0. On out_ready -> IDLE, out_valid=0 next cycle; Result keeps its last value.
- Latency (accept edge to out_valid high):
  - Single-cycle ops: 1 cycle.
  - MUL/MULHU/DIVU/REMU: WIDTH+1 cycles (33 for WIDTH=32).
- Arithmetic:
  - ADD/SUB: {C,sum} = A + (SUB ? ~B : B) + SUB, WIDTH+1 bits.
  - V = (A[msb] ^ sum[msb]) & ~(A[msb] ^ B[msb] ^ SUB).
  - SLT: signed compare, result {0,...,lt}. SLTU: unsigned compare.
  - SRA: sign-fills. SLL/SRL: zero-fill.
  - Z and N are derived from the final registered Result for every op.
- Boundaries:
  - DIVU by 0: Result all ones. REMU by 0: Result = A. Both have single-cycle latency.
  - Reserved op: Result 0, Z=1, 1-cycle latency.
  - Shift by 0: Result = A.
  - in_valid asserted while busy: ignored, not queued.
  - out_ready asserted with out_valid low: no effect.

Test Plan:
- ADD A=0x7FFFFFFF, B=0x00000001 -> out_valid 1 cycle after accept; Result 0x80000000, N=1, V=1, C=0, Z=0.
- SUB A=5, B=5 -> Result 0, Z=1, C=1, V=0. SLT A=0xFFFFFFFF, B=1 -> 1. SLTU same operands -> 0. SRA 0x80000000 by 4 -> 0xF8000000.
- MUL and MULHU, A=B=0xFFFFFFFF -> 0x00000001 and 0xFFFFFFFE respectively; out_valid exactly 33 cycles after accept; in_ready=0 throughout; A/B toggled mid-op have no effect.
- DIVU/REMU A=100, B=7 -> 14 and 2, 33-cycle latency. DIVU 100/0 -> 0xFFFFFFFF, 1 cycle. REMU 100/0 -> 100, 1 cycle.
- Backpressure: ADD result held with out_ready=0 for 5 cycles -> Result/flags/out_valid stable, in_ready=0. out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
- rst=0 on cycle 10 of a DIVU -> next cycle in_ready=1, out_valid=0, Result=0. A subsequent ADD 2+3 returns 5 with 1-cycle latency.
